piso_serializer: RTL
====================

Name: piso_serializer

Overview:
- Parallel-in/serial-out stage that sits directly upstream of the SIPO register and drives its serial input.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per enabled clock, with a frame-last marker.
- Has a one-word holding buffer, so consecutive words stream with no idle cycle between frames.

Parameters:
- WIDTH, 8, bits per word; legal range 2..64.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  single system clock; everything samples on the rising edge.
- arst_n  input  1  asynchronous assert, active-low reset.
- par_data_i  input  WIDTH  parallel word from upstream.
- par_valid_i  input  1  par_data_i is valid.
- par_ready_o  output  1  block can accept a word this cycle.
- ser_en_i  input  1  downstream shift enable; 0 stalls the serial side.
- ser_data_o  output  1  serial bit to the SIPO.
- ser_valid_o  output  1  ser_data_o carries a frame bit.
- ser_last_o  output  1  current bit is the final bit of its word.
- busy_o  output  1  shift register or holding buffer is occupied.

Behaviour:
- Reset (arst_n=0, takes effect immediately): all outputs 0 except par_ready_o=1; shift register, holding buffer and bit counter are cleared; state = IDLE.
- Reset asserted mid-word: the partial frame is discarded, with no further ser_valid_o. Releasing reset returns to IDLE with an empty buffer.
- Handshake: a word is accepted on a rising edge when par_valid_i=1 and par_ready_o=1.
  - par_ready_o = NOT hold_full; it is a registered output.
  - par_data_i and par_valid_i may change freely while par_ready_o=0.
- State machine:
  - IDLE: nothing is shifting. An accept loads the shift register directly and moves to SHIFT; the holding buffer stays empty.
  - SHIFT: a word is being serialized. An accept in this state writes the holding buffer (hold_full=1).
- Shift progression in SHIFT:
  - The bit counter runs 0..WIDTH-1 and advances only on cycles with ser_en_i=1.
  - On the final bit (count=WIDTH-1) with ser_en_i=1:
    - If hold_full: load the buffer into the shift register and clear hold_full in that same edge. The next cycle carries the new word's first bit (zero-gap streaming).
    - Otherwise: go to IDLE.
- Latency: a word accepted at edge N presents its first bit at ser_data_o/ser_valid_o after edge N. Outputs are registered, with no combinational path from any input.
- Outputs:
  - ser_valid_o = 1 throughout SHIFT, including stalled cycles.
  - ser_last_o = 1 while count=WIDTH-1.
  - The downstream consumer qualifies each bit with ser_valid_o AND ser_en_i.
- Stall: when ser_en_i=0, ser_data_o, ser_last_o, the counter and the shift register all hold. The holding buffer may still be filled.
- Simultaneous events:
  - An accept on the same edge the final bit retires with hold_full=0 loads the shift register directly; streaming continues with no gap.
  - An accept while hold_full=1 is impossible, because par_ready_o=0.
- busy_o = (state==SHIFT) OR hold_full.

Decomposition:
- Package sipo_pkg:
  - Default WIDTH constant, shared with the SIPO register and the bench.
  - Enum state_e {IDLE, SHIFT}.
  - Bit-order localparams MSB_FIRST_C and LSB_FIRST_C.
- No sub-module. The holding buffer, counter and shift register are small enough to implement inline; target 150-250 lines.

Test Plan:
- Single word, WIDTH=8, MSB_FIRST=1, ser_en_i=1, send 0xA5 -> ser_data_o=1,0,1,0,0,1,0,1 over 8 cycles starting the cycle after the accept; ser_last_o high only on the 8th; then IDLE, busy_o=0.
- Back-to-back 0xA5 then 0x3C, both presented immediately -> 16 contiguous ser_valid_o cycles; 0x3C bits 0,0,1,1,1,1,0,0 with no gap; ser_last_o on cycles 8 and 16.
- Backpressure: hold par_valid_i=1 with three words -> par_ready_o drops after the 2nd accept and rises when the 1st word's last bit retires; the third word is accepted exactly then.
- Stall: ser_en_i=0 for 3 cycles after bit 3 of 0xF0 -> ser_data_o held at 0 for 3 cycles; total frame length is 11 cycles; bit order unchanged.
- LSB_FIRST instance (MSB_FIRST=0), send 0x01 -> first bit 1, then seven 0s.
- Reset mid-frame: assert arst_n after bit 4 of 0xAA -> ser_valid_o=0 immediately, par_ready_o=1; after release, sending 0x55 produces a clean 8-bit frame with no residue.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared definitions for the serial link: default word width, bit-order
// selectors and the serializer state encoding.
package sipo_pkg;

    localparam int WIDTH_C     = 8;
    localparam bit MSB_FIRST_C = 1'b1;
    localparam bit LSB_FIRST_C = 1'b0;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage with a one-word holding buffer so consecutive
// words stream without an idle cycle between frames.
module piso_serializer
    import sipo_pkg::*;
#(
    parameter int WIDTH     = WIDTH_C,
    parameter bit MSB_FIRST = MSB_FIRST_C
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [WIDTH-1:0] par_data_i,
    input  logic             par_valid_i,
    output logic             par_ready_o,
    input  logic             ser_en_i,
    output logic             ser_data_o,
    output logic             ser_valid_o,
    output logic             ser_last_o,
    output logic             busy_o
);

    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

    state_e           r_state;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_full;
    logic             r_ready;
    logic [CW-1:0]    r_cnt;

    state_e           w_state_nxt;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [WIDTH-1:0] w_hold_nxt;
    logic             w_hold_full_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] w_shifted;
    logic             w_accept;
    logic             w_last;
    logic             w_retire;

    assign w_accept  = par_valid_i & r_ready;
    assign w_last    = (r_cnt == LAST_CNT);
    assign w_retire  = (r_state == SHIFT) & ser_en_i & w_last;
    assign w_shifted = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0} : {1'b0, r_shift[WIDTH-1:1]};

    // NOTE: every next-state signal gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt     = r_state;
        w_shift_nxt     = r_shift;
        w_hold_nxt      = r_hold;
        w_hold_full_nxt = r_hold_full;
        w_cnt_nxt       = r_cnt;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_shift_nxt = par_data_i;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (ser_en_i && w_last) begin
                    w_cnt_nxt = '0;
                    if (r_hold_full) begin
                        w_shift_nxt     = r_hold;
                        w_hold_full_nxt = 1'b0;
                    end else if (w_accept) begin
                        w_shift_nxt = par_data_i;
                    end else begin
                        w_shift_nxt = '0;
                        w_state_nxt = IDLE;
                    end
                end else if (ser_en_i) begin
                    w_shift_nxt = w_shifted;
                    w_cnt_nxt   = r_cnt + CW'(1);
                end
                // A word arriving while the last bit retires bypasses the buffer.
                if (w_accept && !w_retire) begin
                    w_hold_nxt      = par_data_i;
                    w_hold_full_nxt = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_ready     <= 1'b1;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_shift     <= w_shift_nxt;
            r_hold      <= w_hold_nxt;
            r_hold_full <= w_hold_full_nxt;
            r_ready     <= ~w_hold_full_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    assign par_ready_o = r_ready;
    assign ser_data_o  = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
    assign ser_valid_o = (r_state == SHIFT);
    assign ser_last_o  = (r_state == SHIFT) & w_last;
    assign busy_o      = (r_state == SHIFT) | r_hold_full;

endmodule
